// File: rtl/id_ex_stage_if.sv
// ID/EX stage handshake bundle: decoder-side inputs and execute-side outputs.
// master drives the ID side and ex_ready; slave is the pipeline register itself.
interface id_ex_stage_if #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned OP_LOW_W   = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  flush;
    logic                  id_valid;
    logic                  id_ready;
    logic [OP_LOW_W+2:0]   id_exop;
    logic [WORD_W-1:0]     id_srcLeft;
    logic [WORD_W-1:0]     id_srcRight;
    logic [WORD_W-1:0]     id_offset;
    logic [REG_ADDR_W-1:0] id_dest;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [2:0]            ex_alusel;
    logic [OP_LOW_W-1:0]   ex_aluop;
    logic [WORD_W-1:0]     ex_srcLeft;
    logic [WORD_W-1:0]     ex_srcRight;
    logic [WORD_W-1:0]     ex_offset;
    logic [1:0]            ex_memop;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_writeEnable;
    logic [CNT_W-1:0]      ex_bubbleCount;

    modport master (
        output flush, id_valid, id_exop, id_srcLeft, id_srcRight, id_offset, id_dest, ex_ready,
        input  id_ready, ex_valid, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_offset,
               ex_memop, ex_dest, ex_writeEnable, ex_bubbleCount
    );

    modport slave (
        input  flush, id_valid, id_exop, id_srcLeft, id_srcRight, id_offset, id_dest, ex_ready,
        output id_ready, ex_valid, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_offset,
               ex_memop, ex_dest, ex_writeEnable, ex_bubbleCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush, class decode and bubble counter.
// Define ID_EX_SKID_EN to add a one-entry skid buffer that registers id_ready.
module id_ex_stage #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned OP_LOW_W   = 5,
    parameter int unsigned CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam int unsigned OP_W = 3 + OP_LOW_W;

    typedef struct packed {
        logic [2:0]            alusel;
        logic [OP_LOW_W-1:0]   aluop;
        logic [WORD_W-1:0]     src_left;
        logic [WORD_W-1:0]     src_right;
        logic [WORD_W-1:0]     offset;
        logic [1:0]            memop;
        logic [REG_ADDR_W-1:0] dest;
        logic                  write_enable;
    } payload_t;

    payload_t         dec;
    payload_t         out_q, out_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             accept;

    always_comb begin
        dec           = '0;
        dec.aluop     = bus.id_exop[OP_LOW_W-1:0];
        dec.src_left  = bus.id_srcLeft;
        dec.src_right = bus.id_srcRight;
        dec.offset    = bus.id_offset;
        dec.dest      = bus.id_dest;
        case (bus.id_exop[OP_W-1 -: 3])
            3'd1:    begin dec.alusel = 3'd1; dec.memop = 2'd1; dec.write_enable = 1'b1; end
            3'd2:    begin dec.alusel = 3'd2; dec.memop = 2'd1; dec.write_enable = 1'b1; end
            3'd3:    begin dec.alusel = 3'd3; dec.memop = 2'd1; dec.write_enable = 1'b1; end
            3'd4:    begin dec.alusel = 3'd4; dec.memop = 2'd1; dec.write_enable = 1'b1; end
            3'd5:    begin dec.alusel = 3'd3; dec.memop = 2'd2; dec.write_enable = 1'b1; end
            3'd6:    begin dec.alusel = 3'd3; dec.memop = 2'd3; dec.write_enable = 1'b0; end
            default: begin dec.alusel = 3'd0; dec.memop = 2'd0; dec.write_enable = 1'b0; end
        endcase
        // Register 0 is never written.
        if (bus.id_dest == '0) dec.write_enable = 1'b0;
    end

    assign load   = !valid_q || bus.ex_ready;
    assign accept = bus.id_valid && bus.id_ready;

`ifdef ID_EX_SKID_EN
    payload_t skid_q, skid_d;
    logic     skid_full_q, skid_full_d;

    assign bus.id_ready = !rst && !skid_full_q;

    always_comb begin
        valid_d     = valid_q;
        out_d       = out_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            out_d       = '0;
            skid_full_d = 1'b0;
        end else if (load) begin
            // A parked instruction is older than anything offered now.
            if (skid_full_q) begin
                out_d       = skid_q;
                valid_d     = 1'b1;
                skid_full_d = 1'b0;
            end else begin
                valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    assign bus.id_ready = !rst && load;

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            out_d   = '0;
        end else if (load) begin
            valid_d = bus.id_valid;
            if (bus.id_valid) out_d = dec;
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (bus.ex_ready && !valid_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_alusel      = out_q.alusel;
    assign bus.ex_aluop       = out_q.aluop;
    assign bus.ex_srcLeft     = out_q.src_left;
    assign bus.ex_srcRight    = out_q.src_right;
    assign bus.ex_offset      = out_q.offset;
    assign bus.ex_memop       = out_q.memop;
    assign bus.ex_dest        = out_q.dest;
    assign bus.ex_writeEnable = out_q.write_enable;
    assign bus.ex_bubbleCount = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: reset, decode, stall/skid, flush, bubbles, throughput.
module tb_id_ex_stage;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OP_LOW_W   = 5;
    localparam int unsigned CNT_W      = 16;

    typedef struct packed {
        logic [2:0]  alusel;
        logic [4:0]  aluop;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] o;
        logic [1:0]  memop;
        logic [4:0]  dest;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_got;

    always #5 clk = ~clk;

    id_ex_stage_if #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .OP_LOW_W(OP_LOW_W),
                     .CNT_W(CNT_W)) bus ();
    id_ex_stage_if #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .OP_LOW_W(OP_LOW_W),
                     .CNT_W(2)) bus2 ();

    id_ex_stage #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .OP_LOW_W(OP_LOW_W),
                  .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    id_ex_stage #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .OP_LOW_W(OP_LOW_W),
                  .CNT_W(2)) dut_small (.clk(clk), .rst(rst), .bus(bus2));

    function automatic exp_t model(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                                   input logic [31:0] o, input logic [4:0] d);
        exp_t e;
        e.aluop = op[4:0];
        e.l     = l;
        e.r     = r;
        e.o     = o;
        e.dest  = d;
        case (op[7:5])
            3'd1: {e.alusel, e.memop, e.we} = {3'd1, 2'd1, 1'b1};
            3'd2: {e.alusel, e.memop, e.we} = {3'd2, 2'd1, 1'b1};
            3'd3: {e.alusel, e.memop, e.we} = {3'd3, 2'd1, 1'b1};
            3'd4: {e.alusel, e.memop, e.we} = {3'd4, 2'd1, 1'b1};
            3'd5: {e.alusel, e.memop, e.we} = {3'd3, 2'd2, 1'b1};
            3'd6: {e.alusel, e.memop, e.we} = {3'd3, 2'd3, 1'b0};
            default: {e.alusel, e.memop, e.we} = {3'd0, 2'd0, 1'b0};
        endcase
        if (d == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    // Every consumed output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            checks++;
            mon_got = {bus.ex_alusel, bus.ex_aluop, bus.ex_srcLeft, bus.ex_srcRight,
                       bus.ex_offset, bus.ex_memop, bus.ex_dest, bus.ex_writeEnable};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got %h required no output", mon_got);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e) begin
                    errors++;
                    $display("FAIL out_payload got %h required %h", mon_got, mon_e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] op, input logic [31:0] l,
                        input logic [31:0] r, input logic [31:0] o, input logic [4:0] d,
                        input logic rdy, input logic fl, output logic acc);
        @(posedge clk);
        #1;
        bus.id_valid    = v;
        bus.id_exop     = op;
        bus.id_srcLeft  = l;
        bus.id_srcRight = r;
        bus.id_offset   = o;
        bus.id_dest     = d;
        bus.ex_ready    = rdy;
        bus.flush       = fl;
        @(negedge clk);
        acc = v && bus.id_ready && !fl;
        if (fl) sb.delete();
        else if (acc) sb.push_back(model(op, l, r, o, d));
        #1;
    endtask

    task automatic drain();
        logic acc;
        int   budget = 12;
        while (sb.size() != 0 && budget > 0) begin
            step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, acc);
            budget--;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.id_valid    = 1'($urandom);
            bus.id_exop     = 8'($urandom);
            bus.id_srcLeft  = $urandom;
            bus.id_srcRight = $urandom;
            bus.id_offset   = $urandom;
            bus.id_dest     = 5'($urandom);
            bus.ex_ready    = 1'($urandom);
            bus.flush       = 1'($urandom);
            bus2.ex_ready   = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b required 0", bus.ex_valid);
        end
        checks++;
        if (bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL reset_id_ready got %b required 0", bus.id_ready);
        end
        checks++;
        if ({bus.ex_alusel, bus.ex_aluop, bus.ex_srcLeft, bus.ex_srcRight, bus.ex_offset,
             bus.ex_memop, bus.ex_dest, bus.ex_writeEnable} !== '0) begin
            errors++; $display("FAIL reset_payload got nonzero required 0");
        end
        checks++;
        if (bus.ex_bubbleCount !== 16'd0) begin
            errors++; $display("FAIL reset_count got %0d required 0", bus.ex_bubbleCount);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.id_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.ex_ready  = 1'b1;
        bus2.ex_ready = 1'b1;
    endtask

    task automatic test_bubbles();
        logic acc;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, acc);
            if (i == 2) begin
                checks++;
                if (bus2.ex_bubbleCount !== 2'd2) begin
                    errors++; $display("FAIL small_count2 got %0d required 2", bus2.ex_bubbleCount);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.ex_bubbleCount !== 16'd5) begin
                    errors++; $display("FAIL bubble_count5 got %0d required 5", bus.ex_bubbleCount);
                end
            end
        end
        checks++;
        if (bus2.ex_bubbleCount !== 2'd3) begin
            errors++; $display("FAIL small_saturate got %0d required 3", bus2.ex_bubbleCount);
        end
    endtask

    task automatic test_decode();
        logic       acc;
        int         n_acc = 0;
        logic [2:0] cls;
        for (int c = 0; c < 8; c++) begin
            cls = 3'(c);
            step(1'b1, {cls, 5'($urandom)}, $urandom, $urandom, $urandom, 5'd3, 1'b1, 1'b0, acc);
            if (acc) n_acc++;
        end
        step(1'b1, {3'd1, 5'd7}, 32'h5, 32'h6, 32'h7, 5'd0, 1'b1, 1'b0, acc);
        if (acc) n_acc++;
        step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, acc);
        checks++;
        if (bus.ex_writeEnable !== 1'b0 || bus.ex_alusel !== 3'd1 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL dest0_we got we=%b sel=%0d v=%b required we=0 sel=1 v=1",
                     bus.ex_writeEnable, bus.ex_alusel, bus.ex_valid);
        end
        checks++;
        if (n_acc != 9) begin
            errors++; $display("FAIL decode_accept got %0d required 9", n_acc);
        end
        drain();
    endtask

    task automatic test_stall();
        logic acc;
        logic b_sent = 1'b0;
        logic exp_rdy;
        step(1'b1, {3'd1, 5'd2}, 32'h0000_00FF, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0, acc);
        for (int c = 0; c < 3; c++) begin
            step(!b_sent, {3'd3, 5'd4}, 32'h1234, 32'h10, 32'h20, 5'd9, 1'b0, 1'b0, acc);
            if (acc) b_sent = 1'b1;
`ifdef ID_EX_SKID_EN
            exp_rdy = (c == 0);
`else
            exp_rdy = 1'b0;
`endif
            checks++;
            if (bus.id_ready !== exp_rdy) begin
                errors++; $display("FAIL stall_id_ready c=%0d got %b required %b", c, bus.id_ready,
                                   exp_rdy);
            end
            checks++;
            if ({bus.ex_valid, bus.ex_alusel, bus.ex_srcLeft, bus.ex_memop, bus.ex_writeEnable,
                 bus.ex_dest} !== {1'b1, 3'd1, 32'h0000_00FF, 2'd1, 1'b1, 5'd7}) begin
                errors++; $display("FAIL stall_hold c=%0d got v=%b sel=%0d l=%h required 1 1 ff",
                                   c, bus.ex_valid, bus.ex_alusel, bus.ex_srcLeft);
            end
        end
        step(!b_sent, {3'd3, 5'd4}, 32'h1234, 32'h10, 32'h20, 5'd9, 1'b1, 1'b0, acc);
        if (acc) b_sent = 1'b1;
        step(!b_sent, {3'd3, 5'd4}, 32'h1234, 32'h10, 32'h20, 5'd9, 1'b1, 1'b0, acc);
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_alusel !== 3'd3 || bus.ex_srcLeft !== 32'h1234) begin
            errors++; $display("FAIL release_second got v=%b sel=%0d l=%h required 1 3 1234",
                               bus.ex_valid, bus.ex_alusel, bus.ex_srcLeft);
        end
        drain();
    endtask

    task automatic test_flush();
        logic acc;
        logic exp_rdy;
        int   live = 0;
        step(1'b1, {3'd3, 5'd1}, 32'hAAAA, 32'hBBBB, 32'h11, 5'd4, 1'b1, 1'b0, acc);
        step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, acc);
        step(1'b1, {3'd3, 5'd2}, 32'hCCCC, 32'hDDDD, 32'h22, 5'd5, 1'b0, 1'b1, acc);
`ifdef ID_EX_SKID_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        checks++;
        if (bus.id_ready !== exp_rdy) begin
            errors++; $display("FAIL flush_id_ready got %b required %b", bus.id_ready, exp_rdy);
        end
        step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, acc);
        checks++;
        if ({bus.ex_valid, bus.ex_alusel, bus.ex_srcLeft, bus.ex_srcRight, bus.ex_offset,
             bus.ex_memop, bus.ex_dest, bus.ex_writeEnable} !== '0) begin
            errors++; $display("FAIL flush_clear got v=%b l=%h r=%h required all 0",
                               bus.ex_valid, bus.ex_srcLeft, bus.ex_srcRight);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, acc);
            if (bus.ex_valid) live++;
        end
        checks++;
        if (live != 0) begin
            errors++; $display("FAIL flush_drop got %0d live cycles required 0", live);
        end
    endtask

    task automatic test_back_to_back();
        logic        acc;
        int          n_acc = 0;
        int          n_valid = 0;
        logic [15:0] snap = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, {3'(1 + $urandom_range(0, 5)), 5'($urandom)}, $urandom, $urandom, $urandom,
                 5'($urandom), 1'b1, 1'b0, acc);
            if (acc) n_acc++;
            if (i >= 1 && bus.ex_valid) n_valid++;
            if (i == 1) snap = bus.ex_bubbleCount;
        end
        step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, acc);
        if (bus.ex_valid) n_valid++;
        checks++;
        if (n_acc != 16) begin
            errors++; $display("FAIL b2b_accept got %0d required 16", n_acc);
        end
        checks++;
        if (n_valid != 16) begin
            errors++; $display("FAIL b2b_valid got %0d required 16", n_valid);
        end
        checks++;
        if (bus.ex_bubbleCount !== snap) begin
            errors++; $display("FAIL b2b_bubbles got %0d required %0d", bus.ex_bubbleCount, snap);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
        bus.flush        = 1'b0;
        bus.id_valid     = 1'b0;
        bus.id_exop      = '0;
        bus.id_srcLeft   = '0;
        bus.id_srcRight  = '0;
        bus.id_offset    = '0;
        bus.id_dest      = '0;
        bus.ex_ready     = 1'b0;
        bus2.flush       = 1'b0;
        bus2.id_valid    = 1'b0;
        bus2.id_exop     = '0;
        bus2.id_srcLeft  = '0;
        bus2.id_srcRight = '0;
        bus2.id_offset   = '0;
        bus2.id_dest     = '0;
        bus2.ex_ready    = 1'b0;
        test_reset();
        test_bubbles();
        test_decode();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID→EX pipeline register with a valid/ready handshake, stall back-pressure, flush, and decode of the high EX-op field into ALU select, memory op and write enable for six instruction classes. Sits between the decoder (ID) and the execute unit (EX). It generalises the fixed logic-only ID/EX latch to configurable widths, stalls, squashing and a bubble counter. An optional skid entry breaks the combinational ready path.

## Interface
Parameters:
- WORD_W, 32, datapath word width (srcLeft, srcRight, offset)
- REG_ADDR_W, 5, destination register address width
- OP_LOW_W, 5, low (ALU-op) part of the EX op; full op width is 3+OP_LOW_W
- CNT_W, 16, bubble counter width

Ports (clock and reset are `clk` and `rst`; one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all held and incoming instructions this cycle
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts this cycle
- id_exop  in  3+OP_LOW_W  [top 3] class, [OP_LOW_W-1:0] ALU op
- id_srcLeft, id_srcRight, id_offset  in  WORD_W  operands and offset
- id_dest  in  REG_ADDR_W  destination register
- ex_valid  out  1  outputs hold a live instruction
- ex_ready  in  1  EX consumes this cycle
- ex_alusel  out  3  0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MOVE
- ex_aluop  out  OP_LOW_W  low op bits
- ex_srcLeft, ex_srcRight, ex_offset  out  WORD_W
- ex_memop  out  2  0 NOP, 1 WRITE_REG, 2 LOAD, 3 STORE
- ex_dest  out  REG_ADDR_W
- ex_writeEnable  out  1
- ex_bubbleCount  out  CNT_W  cycles with ex_ready=1 and ex_valid=0

## Operation
- Class decode (registered with the data): 0 NOP→(NOP,NOP,0); 1 LOGIC→(LOGIC,WRITE_REG,1); 2 SHIFT→(SHIFT,WRITE_REG,1); 3 ARITH→(ARITH,WRITE_REG,1); 4 MOVE→(MOVE,WRITE_REG,1); 5 LOAD→(ARITH,LOAD,1); 6 STORE→(ARITH,STORE,0); 7 reserved→as NOP.
- Writes with id_dest=0 force ex_writeEnable=0. The other fields are unchanged.
- Transfer in: id_valid & id_ready. Transfer out: ex_valid & ex_ready.
- Output register loads when empty or draining (`!ex_valid | ex_ready`). When holding (ex_valid & !ex_ready) the outputs stay stable bit-for-bit.
- Simultaneous drain and accept: the new instruction appears next cycle with ex_valid=1 and no bubble.
- flush: next cycle ex_valid=0 and the skid entry is empty. Payload outputs return to reset values. The instruction offered that cycle is dropped, but id_ready still reports normally.
- A NOP-class instruction still travels as valid (ex_valid=1, all controls off).
- ex_bubbleCount increments on each cycle with ex_ready & !ex_valid. It saturates at all-ones.

## Timing
- Latency: 1 cycle ID→EX when not stalled.
- id_ready (macro off) = `!ex_valid | ex_ready`. This is combinational from ex_ready.
- Reset (rst=1 at a clock edge), all outputs: ex_valid=0, ex_alusel=0, ex_aluop=0, srcLeft/srcRight/offset=0, ex_memop=0, ex_dest=0, ex_writeEnable=0, ex_bubbleCount=0. The skid is empty.
- id_ready during rst: 0.
- Reset mid-stall discards the held and skid instructions.
- Priority: rst > flush > transfer.
- The counter is not affected by flush.

## Configuration
- ID_EX_SKID_EN defined: a one-entry skid buffer is added.
  - id_ready is a flop: `!skid_full`.
  - An instruction accepted while the output is held goes to the skid. The skid moves to the output on the next drain, before new input.
  - Throughput stays 1/cycle.
  - On the cycle after ex_ready falls, id_ready is still 1, which allows one extra accept.
- Undefined: no skid. id_ready is the combinational expression above.

## Test plan
- Reset: rst high 2 cycles with random inputs → every output 0, ex_valid=0, id_ready=0.
- Decode sweep: back-to-back classes 0–7, ex_ready=1, id_dest=3 → the next cycle shows each mapped triple. STORE gives (3,3,0). Class 7 gives (0,0,0). Then LOGIC with id_dest=0 → ex_writeEnable=0.
- Stall: LOGIC srcLeft=0x0000_00FF is accepted, then ex_ready=0 for 3 cycles → outputs constant and id_ready=0. Skid build: one extra instruction is accepted into the skid, then id_ready=0. After release, the two instructions emerge in order on consecutive cycles.
- Flush: flush while holding an ARITH with a new one offered → next cycle ex_valid=0, srcs=0, and neither instruction ever appears.
- Bubbles: ex_ready=1 and id_valid=0 for 5 cycles from reset → ex_bubbleCount=5. With CNT_W=2 and 6 idle cycles → count holds at 3.
- Throughput: 16 back-to-back ops with ex_ready=1 → 16 consecutive ex_valid cycles, in order, and no bubble count increment.
